// File: rtl/mix_columns.sv
// Iterative AES MixColumns / InvMixColumns stage: one shared column datapath
// processes the four columns over four cycles, with a bypass for the final round.
module mix_columns (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         fwd_ninv_i,
  input  logic         bypass_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] in_state,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] out_state
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t       state;
  logic [127:0] src_q;
  logic         fwd_q;
  logic [1:0]   col_cnt;

  logic [127:0] src_shift;
  logic [7:0]   a0, a1, a2, a3;
  logic [7:0]   b0, b1, b2, b3;
  logic [127:0] col_ins;
  logic [127:0] col_mask;
  logic [127:0] out_next;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // One output byte of a column; inputs are already rotated so a0 is the
  // byte in the same row as the result.
  function automatic logic [7:0] mix_byte(input logic [7:0] x0, input logic [7:0] x1,
                                          input logic [7:0] x2, input logic [7:0] x3,
                                          input logic fwd);
    logic [7:0] x0_2, x0_4, x0_8;
    logic [7:0] x1_2, x1_4, x1_8;
    logic [7:0] x2_2, x2_4, x2_8;
    logic [7:0] x3_2, x3_4, x3_8;
    x0_2 = xtime(x0); x0_4 = xtime(x0_2); x0_8 = xtime(x0_4);
    x1_2 = xtime(x1); x1_4 = xtime(x1_2); x1_8 = xtime(x1_4);
    x2_2 = xtime(x2); x2_4 = xtime(x2_2); x2_8 = xtime(x2_4);
    x3_2 = xtime(x3); x3_4 = xtime(x3_2); x3_8 = xtime(x3_4);
    if (fwd)
      return x0_2 ^ (x1_2 ^ x1) ^ x2 ^ x3;
    else
      return (x0_8 ^ x0_4 ^ x0_2) ^ (x1_8 ^ x1_2 ^ x1) ^
             (x2_8 ^ x2_4 ^ x2) ^ (x3_8 ^ x3);
  endfunction

  assign in_ready_o = (state == IDLE);

  // Shifting by whole bytes brings the current column to byte 0 of every row,
  // so the datapath only ever looks at fixed bit positions.
  always_comb begin
    src_shift = src_q << {col_cnt, 3'b000};
    a0 = src_shift[127 -: 8];
    a1 = src_shift[95  -: 8];
    a2 = src_shift[63  -: 8];
    a3 = src_shift[31  -: 8];
    b0 = mix_byte(a0, a1, a2, a3, fwd_q);
    b1 = mix_byte(a1, a2, a3, a0, fwd_q);
    b2 = mix_byte(a2, a3, a0, a1, fwd_q);
    b3 = mix_byte(a3, a0, a1, a2, fwd_q);
    col_ins  = {b0, 24'h0, b1, 24'h0, b2, 24'h0, b3, 24'h0} >> {col_cnt, 3'b000};
    col_mask = {4{8'hff, 24'h0}} >> {col_cnt, 3'b000};
    out_next = (out_state & ~col_mask) | col_ins;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      src_q       <= '0;
      fwd_q       <= 1'b1;
      col_cnt     <= '0;
      out_state   <= '0;
      out_valid_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid_i) begin
            src_q   <= in_state;
            fwd_q   <= fwd_ninv_i;
            col_cnt <= '0;
            if (bypass_i) begin
              out_state   <= in_state;
              out_valid_o <= 1'b1;
              state       <= DONE;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          out_state <= out_next;
          col_cnt   <= col_cnt + 2'd1;
          if (col_cnt == 2'd3) begin
            out_valid_o <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mix_columns.sv
// Directed bench for mix_columns: FIPS-197 vectors, inverse, bypass,
// backpressure, input hold and reset in the middle of a transform.
module tb_mix_columns;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         fwd_ninv_i;
  logic         bypass_i;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [127:0] in_state;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [127:0] out_state;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] FIPS_IN  = 128'hdbf201c6_130a01c6_532201c6_455c01c6;
  localparam logic [127:0] FIPS_OUT = 128'h8e9f01c6_4ddc01c6_a15801c6_bc9d01c6;
  localparam logic [127:0] ALT_IN   = 128'hd42dc601_d426c601_d431c601_d54cc601;
  localparam logic [127:0] ALT_OUT  = 128'hd54dc601_d57ec601_d7bdc601_d6f8c601;
  localparam logic [127:0] BYP_IN   = 128'h000102030405060708090A0B0C0D0E0F;

  mix_columns dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .fwd_ninv_i  (fwd_ninv_i),
    .bypass_i    (bypass_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_state    (in_state),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_state   (out_state)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    n_checks++;
    assert (observed === expected)
      else begin
        n_fail++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  // Presents one state for a single acceptance edge, then withdraws it.
  task automatic accept(input logic [127:0] st, input logic fwd, input logic byp);
    in_state   = st;
    fwd_ninv_i = fwd;
    bypass_i   = byp;
    in_valid_i = 1'b1;
    check("ready_before_accept", {127'b0, in_ready_o}, 128'd1);
    step();
    in_valid_i = 1'b0;
  endtask

  initial begin
    rst_i       = 1'b1;
    fwd_ninv_i  = 1'b1;
    bypass_i    = 1'b0;
    in_valid_i  = 1'b1;
    in_state    = FIPS_IN;
    out_ready_i = 1'b0;
    step();
    step();
    check("reset_out_valid", {127'b0, out_valid_o}, 128'd0);
    check("reset_out_state", out_state, 128'd0);
    check("reset_in_ready",  {127'b0, in_ready_o}, 128'd1);
    in_valid_i = 1'b0;
    rst_i      = 1'b0;
    step();

    $display("[TB] forward FIPS-197 vector with backpressure");
    accept(FIPS_IN, 1'b1, 1'b0);
    check("fwd_busy_ready", {127'b0, in_ready_o}, 128'd0);
    for (int i = 1; i <= 3; i++) begin
      step();
      check("fwd_not_yet_valid", {127'b0, out_valid_o}, 128'd0);
    end
    step();
    check("fwd_valid_at_e4", {127'b0, out_valid_o}, 128'd1);
    check("fwd_result", out_state, FIPS_OUT);
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_valid_held", {127'b0, out_valid_o}, 128'd1);
      check("bp_state_stable", out_state, FIPS_OUT);
      check("bp_ready_low", {127'b0, in_ready_o}, 128'd0);
    end

    $display("[TB] release backpressure, inverse vector with input changes during busy");
    out_ready_i = 1'b1;
    in_valid_i  = 1'b1;
    in_state    = FIPS_OUT;
    fwd_ninv_i  = 1'b0;
    bypass_i    = 1'b0;
    step();
    check("hs_valid_fall", {127'b0, out_valid_o}, 128'd0);
    check("hs_ready_rise", {127'b0, in_ready_o}, 128'd1);
    check("idle_state_kept", out_state, FIPS_OUT);
    step();
    in_valid_i = 1'b0;
    check("inv_accepted", {127'b0, in_ready_o}, 128'd0);
    in_state   = {4{32'hdeadbeef}};
    fwd_ninv_i = 1'b1;
    bypass_i   = 1'b1;
    step();
    in_state   = '1;
    fwd_ninv_i = 1'b0;
    step();
    fwd_ninv_i = 1'b1;
    step();
    check("inv_not_yet_valid", {127'b0, out_valid_o}, 128'd0);
    step();
    check("inv_valid_at_e4", {127'b0, out_valid_o}, 128'd1);
    check("inv_result", out_state, FIPS_IN);
    step();
    check("inv_hs_first_done", {127'b0, out_valid_o}, 128'd0);

    $display("[TB] second forward and inverse vectors");
    accept(ALT_IN, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step();
    check("alt_fwd_result", out_state, ALT_OUT);
    step();
    accept(ALT_OUT, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step();
    check("alt_inv_result", out_state, ALT_IN);
    step();

    $display("[TB] bypass");
    accept(BYP_IN, 1'b1, 1'b1);
    check("byp_valid_1cyc", {127'b0, out_valid_o}, 128'd1);
    check("byp_result", out_state, BYP_IN);
    step();
    check("byp_hs", {127'b0, out_valid_o}, 128'd0);
    bypass_i = 1'b0;

    $display("[TB] reset during busy column 2");
    accept(FIPS_IN, 1'b1, 1'b0);
    step();
    step();
    rst_i = 1'b1;
    #1;
    check("mid_rst_valid", {127'b0, out_valid_o}, 128'd0);
    check("mid_rst_state", out_state, 128'd0);
    check("mid_rst_ready", {127'b0, in_ready_o}, 128'd1);
    step();
    rst_i = 1'b0;
    step();
    check("post_rst_valid", {127'b0, out_valid_o}, 128'd0);
    accept(FIPS_IN, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step();
    check("post_rst_not_valid", {127'b0, out_valid_o}, 128'd0);
    step();
    check("post_rst_valid_e4", {127'b0, out_valid_o}, 128'd1);
    check("post_rst_result", out_state, FIPS_OUT);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
